ps2_host_rx: RTL and testbench
==============================

Name: ps2_host_rx

Overview:
- Host-side PS/2 receiver. Samples the device-driven ps2_clk/ps2_dat lines, deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop), checks them, and buffers good scancodes in a small FIFO.
- The CPU-side peripheral bridge reads bytes from the FIFO.
- Sits between the keyboard model/pads and the peripheral register interface.
- Receive only; the host never drives ps2_clk or ps2_dat.

Parameters:
- FIFO_DEPTH, 8, number of scancode entries; power of two, >= 2.
- SYNC_STAGES, 2, synchronizer flops per PS/2 input, >= 2.
- TIMEOUT_CYCLES, 25000, clock cycles without a ps2_clk falling edge before an in-progress frame is aborted (1 ms at 25 MHz).

Ports:
- clock  in  1  system clock (25 MHz nominal).
- resetn  in  1  reset; asynchronous, active-low.
- ps2_clk  in  1  PS/2 clock from device; asynchronous.
- ps2_dat  in  1  PS/2 data from device; asynchronous.
- rd_en  in  1  pop the FIFO head; ignored when empty.
- rd_data  out  8  FIFO head byte; valid only while rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- err_clr  in  1  clears the sticky error flags.
- overflow  out  1  sticky; a good byte was dropped because the FIFO was full.
- parity_err  out  1  sticky; a frame was discarded for bad parity.
- frame_err  out  1  sticky; a frame was discarded for bad stop bit or timeout.

Behaviour:
- Reset (resetn low, async): FSM to IDLE; bit counter, shift register, timeout counter and FIFO pointers cleared; synchronizer flops set to 1.
  - Outputs: rd_valid=0, rd_data=0, overflow=0, parity_err=0, frame_err=0.
- Synchronizer: each input passes through SYNC_STAGES flops. clk_prev registers the synchronized clock. A falling edge (fe) is a 1-cycle strobe: clk_prev=1 and sync clk=0. Data is sampled from synchronized ps2_dat in the fe cycle.
- FSM states IDLE, DATA, PARITY, STOP; advances only on fe (except timeout).
  - IDLE: on fe with dat=0, go to DATA and clear bit_cnt. On fe with dat=1, stay in IDLE with no error (idle line toggling is legal).
  - DATA: on fe, shift dat into bit 7 (LSB-first assembly) and increment bit_cnt. After the 8th bit, go to PARITY.
  - PARITY: on fe, latch p = dat and go to STOP.
  - STOP: on fe, return to IDLE.
    - If the data bytes plus p have odd parity and dat=1: push the byte.
    - Else if parity is bad: set parity_err. Parity takes priority when both parity and stop are bad.
    - Else (stop bit 0): set frame_err.
- Timeout: the counter resets on every fe and while in IDLE. If it reaches TIMEOUT_CYCLES-1 in a non-IDLE state, go to IDLE, set frame_err, and discard the partial byte.
  - If timeout and fe coincide, fe wins.
- Push latency: the FIFO write occurs at the clock edge ending the STOP fe cycle. rd_valid is high in the next cycle.
- FIFO:
  - rd_data is combinational from the head entry.
  - rd_en with rd_valid=1 advances the head at the clock edge.
  - Push when full and no pop: byte dropped, overflow set, contents unchanged.
  - Push and pop in the same cycle when full: both take effect, no overflow.
  - Push and pop in the same cycle when empty cannot pop (rd_valid=0); the push still lands.
  - Pointers wrap modulo FIFO_DEPTH. A count of log2(DEPTH)+1 bits distinguishes full from empty.
- Sticky flags:
  - Set by events.
  - err_clr clears them at the clock edge. A set event in the same cycle as err_clr wins (flag stays 1).
- resetn asserted mid-frame: everything returns to the reset state immediately; the partial frame is lost. Re-sync on the next start bit.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state typedef (IDLE/DATA/PARITY/STOP).
  - Frame constants: DATA_BITS=8, FRAME_BITS=11.
  - Odd-parity helper function.
- One sub-module, ps2_rx_fifo (parameterized by width and depth; push/pop/full/empty/head). It is reusable by a future PS/2 mouse receiver.
- Synchronizer and FSM stay in ps2_host_rx.

Test Plan:
- Free-running 10 kHz ps2_clk with ps2_dat held 1 for 20 ms -> rd_valid stays 0; all error flags stay 0.
- Frame for 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> rd_valid rises 1 cycle after the 11th falling edge is detected; rd_data=0x1C; rd_en pulse makes rd_valid 0.
- Same frame with parity bit 1 -> no push; parity_err=1. err_clr pulse -> parity_err=0. A following frame with 0xF0 and parity 1 -> rd_data=0xF0.
- Start plus 4 data bits, then ps2_clk held high for 25000+ cycles -> frame_err=1, FSM in IDLE, no push. A following good 0x5A frame -> rd_data=0x5A.
- Nine good frames 0x01..0x09 with no reads -> overflow=1; reads return 0x01..0x08, then rd_valid=0. Also: 8 bytes full, then a frame whose STOP fe coincides with rd_en -> no overflow; count stays 8.
- Assert resetn mid-DATA (after 3 bits) -> all outputs 0 immediately. After release, a good 0x76 frame is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM state encoding, frame geometry and
// the odd-parity check used on every received frame.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int DATA_BITS  = 8;
  // start + data + parity + stop
  localparam int FRAME_BITS = DATA_BITS + 3;

  // True when data plus the parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                         input logic                 par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Small synchronous FIFO with push/pop, full/empty and a combinational head.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module ps2_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Gated so the head reads zero (not stale storage) when nothing is queued.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_host_rx.sv
// Host-side PS/2 receiver: synchronizes the device clock/data, deframes
// 11-bit frames, checks parity/stop and queues good scancodes.
module ps2_host_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       err_clr,
  output logic       overflow,
  output logic       parity_err,
  output logic       frame_err,
  output logic [1:0] state_dbg
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam int BC_W = $clog2(FRAME_BITS);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   s_clk;
  logic                   s_dat;
  logic                   clk_prev;
  logic                   fe;

  ps2_state_e            state, state_n;
  logic [BC_W-1:0]       bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0]  shreg, shreg_n;
  logic                  par_bit, par_bit_n;
  logic [TO_W-1:0]       to_cnt, to_cnt_n;
  logic                  timeout;

  logic push_req;
  logic perr_evt;
  logic ferr_evt;
  logic ovf_evt;
  logic fifo_full;
  logic fifo_empty;

  // Idle PS/2 lines are high, so the synchronizers reset to 1 to avoid a
  // false falling edge right after reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= s_clk;
    end
  end

  assign s_clk   = clk_sync[SYNC_STAGES-1];
  assign s_dat   = dat_sync[SYNC_STAGES-1];
  assign fe      = clk_prev && !s_clk;
  assign timeout = (state != ST_IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par_bit <= par_bit_n;
      to_cnt  <= to_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    push_req  = 1'b0;
    perr_evt  = 1'b0;
    ferr_evt  = 1'b0;
    to_cnt_n  = (fe || state == ST_IDLE || timeout) ? '0 : to_cnt + TO_W'(1);

    case (state)
      ST_IDLE: begin
        // A high data bit on a falling edge is idle-line activity, not a frame.
        if (fe && !s_dat) begin
          state_n   = ST_DATA;
          bit_cnt_n = '0;
        end
      end
      ST_DATA: begin
        if (fe) begin
          shreg_n   = {s_dat, shreg[DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + BC_W'(1);
          if (bit_cnt == BC_W'(DATA_BITS - 1)) begin
            state_n = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (fe) begin
          par_bit_n = s_dat;
          state_n   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fe) begin
          state_n = ST_IDLE;
          if (odd_parity_ok(shreg, par_bit) && s_dat) begin
            push_req = 1'b1;
          end else if (!odd_parity_ok(shreg, par_bit)) begin
            perr_evt = 1'b1;
          end else begin
            ferr_evt = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A real edge always beats the watchdog.
    if (timeout && !fe) begin
      state_n  = ST_IDLE;
      shreg_n  = '0;
      ferr_evt = 1'b1;
    end
  end

  // Full means no pop can be blocked by emptiness, so rd_en alone frees a slot.
  assign ovf_evt = push_req && fifo_full && !rd_en;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (ovf_evt)       overflow <= 1'b1;
      else if (err_clr)  overflow <= 1'b0;
      if (perr_evt)      parity_err <= 1'b1;
      else if (err_clr)  parity_err <= 1'b0;
      if (ferr_evt)      frame_err <= 1'b1;
      else if (err_clr)  frame_err <= 1'b0;
    end
  end

  ps2_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push_req),
    .push_data (shreg),
    .pop       (rd_en),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (rd_data)
  );

  assign rd_valid  = !fifo_empty;
  assign state_dbg = state;

endmodule

// File: tb/tb_ps2_host_rx.sv
// Directed bench for ps2_host_rx: a vector table of single frames plus
// hand-written sequences for latency, timeout, overflow and mid-frame reset.
module tb_ps2_host_rx;

  localparam int H  = 20;   // PS/2 half period in system clocks
  localparam int TO = 200;  // shortened timeout for simulation

  logic       clock   = 1'b0;
  logic       resetn  = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd_en   = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       overflow;
  logic       parity_err;
  logic       frame_err;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic lat_v1, lat_v2, lat_v3;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_push;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[9];

  // Clock/reset block
  always #5 clock = ~clock;

  ps2_host_rx #(
    .FIFO_DEPTH     (8),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .err_clr    (err_clr),
    .overflow   (overflow),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .state_dbg  (state_dbg)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling system clock edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  task automatic send_bits(input logic [10:0] frame, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = frame[i];
      tick(H);
      ps2_clk = 1'b0;
      tick(H);
      ps2_clk = 1'b1;
    end
  endtask

  // Full frame; optionally strobes rd_en / err_clr in the cycle the stop-bit
  // edge is detected (two system clocks after ps2_clk falls).
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input logic do_rd, input logic do_clr);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    send_bits(f, 10);
    ps2_dat = s;
    tick(H);
    ps2_clk = 1'b0;
    tick(1);
    lat_v1 = rd_valid;
    tick(1);
    lat_v2 = rd_valid;
    if (do_rd) begin
      check8("coinc_head", rd_data, exp_q.pop_front());
      rd_en = 1'b1;
    end
    if (do_clr) err_clr = 1'b1;
    tick(1);
    rd_en   = 1'b0;
    err_clr = 1'b0;
    lat_v3  = rd_valid;
    tick(H - 3);
    ps2_clk = 1'b1;
  endtask

  // Scoreboard pop: head must match the oldest expected byte.
  task automatic pop_check(input string name);
    check1({name, "_valid"}, rd_valid, 1'b1);
    check8(name, rd_data, exp_q.pop_front());
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{8'h76, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    tick(3);
    check1("rst_rd_valid", rd_valid, 1'b0);
    check8("rst_rd_data", rd_data, 8'h00);
    check1("rst_overflow", overflow, 1'b0);
    check1("rst_parity_err", parity_err, 1'b0);
    check1("rst_frame_err", frame_err, 1'b0);
    check8("rst_state", {6'd0, state_dbg}, 8'h00);
    resetn = 1'b1;
    tick(3);

    // Idle line toggling with data high
    ps2_dat = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(H);
      ps2_clk = 1'b0;
      tick(H);
      ps2_clk = 1'b1;
    end
    tick(5);
    check1("idle_rd_valid", rd_valid, 1'b0);
    check1("idle_parity_err", parity_err, 1'b0);
    check1("idle_frame_err", frame_err, 1'b0);
    check8("idle_state", {6'd0, state_dbg}, 8'h00);

    // 0x1C with push latency
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    check1("lat_edge1", lat_v1, 1'b0);
    check1("lat_fe_cycle", lat_v2, 1'b0);
    check1("lat_after_push", lat_v3, 1'b1);
    exp_q.push_back(8'h1C);
    pop_check("x1c");
    check1("x1c_empty", rd_valid, 1'b0);

    // Table-driven single frames
    for (int v = 0; v < 9; v++) begin
      pulse_clr();
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, 1'b0, 1'b0);
      tick(5);
      check1($sformatf("vec%0d_valid", v), rd_valid, vecs[v].exp_push);
      if (vecs[v].exp_push) begin
        exp_q.push_back(vecs[v].data);
        pop_check($sformatf("vec%0d_data", v));
      end
      check1($sformatf("vec%0d_perr", v), parity_err, vecs[v].exp_perr);
      check1($sformatf("vec%0d_ferr", v), frame_err, vecs[v].exp_ferr);
      check1($sformatf("vec%0d_ovf", v), overflow, 1'b0);
    end

    // Set event coinciding with err_clr keeps the flag set
    pulse_clr();
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(2);
    check1("clr_vs_set", parity_err, 1'b1);
    pulse_clr();
    check1("clr_after", parity_err, 1'b0);

    // Timeout mid-frame
    send_bits({1'b1, 1'b1, 8'h0F, 1'b0}, 5);
    tick(TO / 2);
    check8("to_still_data", {6'd0, state_dbg}, 8'h01);
    tick(TO);
    check1("to_frame_err", frame_err, 1'b1);
    check8("to_state_idle", {6'd0, state_dbg}, 8'h00);
    check1("to_no_push", rd_valid, 1'b0);
    pulse_clr();
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(5);
    exp_q.push_back(8'h5A);
    pop_check("to_next");
    check1("to_next_ferr", frame_err, 1'b0);

    // Overflow: nine frames, no reads
    for (int k = 1; k <= 9; k++) begin
      send_frame(8'(k), ~^(8'(k)), 1'b1, 1'b0, 1'b0);
      if (k <= 8) exp_q.push_back(8'(k));
    end
    tick(5);
    check1("ovf_set", overflow, 1'b1);
    for (int k = 0; k < 8; k++) pop_check("ovf_read");
    check1("ovf_drained", rd_valid, 1'b0);

    // Full FIFO, push coinciding with pop
    pulse_clr();
    for (int k = 8'h11; k <= 8'h18; k++) begin
      send_frame(8'(k), ~^(8'(k)), 1'b1, 1'b0, 1'b0);
      exp_q.push_back(8'(k));
    end
    check1("full_valid", rd_valid, 1'b1);
    exp_q.push_back(8'h19);
    send_frame(8'h19, ~^(8'h19), 1'b1, 1'b1, 1'b0);
    tick(5);
    check1("coinc_no_ovf", overflow, 1'b0);
    for (int k = 0; k < 8; k++) pop_check("coinc_read");
    check1("coinc_drained", rd_valid, 1'b0);

    // Reset asserted mid-DATA with a byte queued and an error flagged
    send_frame(8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 4);
    check1("pre_rst_valid", rd_valid, 1'b1);
    check1("pre_rst_perr", parity_err, 1'b1);
    resetn = 1'b0;
    #1;
    check1("mid_rst_valid", rd_valid, 1'b0);
    check8("mid_rst_data", rd_data, 8'h00);
    check1("mid_rst_perr", parity_err, 1'b0);
    check8("mid_rst_state", {6'd0, state_dbg}, 8'h00);
    exp_q.delete();
    tick(3);
    resetn = 1'b1;
    tick(3);
    send_frame(8'h76, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(5);
    exp_q.push_back(8'h76);
    pop_check("post_rst");
    check1("post_rst_empty", rd_valid, 1'b0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
